// File: rtl/rule90_ca_if.sv
// Parallel load/readout bundle for the Rule 90 automaton.
// The driver side owns load/data; the automaton side owns q.
interface rule90_ca_if #(
  parameter int WIDTH = 512
);
  logic             load;
  logic [WIDTH-1:0] data;
  logic [WIDTH-1:0] q;

  modport master (
    output load,
    output data,
    input  q
  );

  modport slave (
    input  load,
    input  data,
    output q
  );
endinterface

// File: rtl/rule90_ca.sv
// WIDTH-cell Rule 90 cellular automaton: each edge every cell takes the XOR of
// its two neighbours, with constant-zero cells beyond both ends.
module rule90_ca #(
  parameter int WIDTH = 512
) (
  input  logic        clk,
  input  logic        rst_n,
  rule90_ca_if.slave  bus
);

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;
  logic [WIDTH-1:0] w_next;

  // Neighbour taps with explicit zero boundary terms; no wrap-around.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_cell
      if (gi == WIDTH - 1) begin : g_left_edge
        assign w_left[gi] = 1'b0;
      end else begin : g_left_tap
        assign w_left[gi] = r_q[gi+1];
      end

      if (gi == 0) begin : g_right_edge
        assign w_right[gi] = 1'b0;
      end else begin : g_right_tap
        assign w_right[gi] = r_q[gi-1];
      end

      // Load beats step; reset is applied in the register below.
      assign w_next[gi] = bus.load ? bus.data[gi] : (w_left[gi] ^ w_right[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else begin
      r_q <= w_next;
    end
  end

  assign bus.q = r_q;

endmodule

// File: tb/tb_rule90_ca.sv
// Directed bench for rule90_ca with hand-computed vectors plus a reference
// model for the longer evolution run.
module tb_rule90_ca;
  localparam int W = 512;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_state;

  rule90_ca_if #(.WIDTH(W)) bus ();

  rule90_ca #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check_q(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] bits4(input int a, input int b, input int c, input int d);
    logic [W-1:0] v;
    v = '0;
    if (a >= 0) v[a] = 1'b1;
    if (b >= 0) v[b] = 1'b1;
    if (c >= 0) v[c] = 1'b1;
    if (d >= 0) v[d] = 1'b1;
    return v;
  endfunction

  // Reference model: one Rule 90 generation with zero cells outside.
  function automatic logic [W-1:0] model_step(input logic [W-1:0] s);
    logic [W-1:0] n;
    logic l, r;
    for (int i = 0; i < W; i++) begin
      l = (i < W - 1) ? s[i+1] : 1'b0;
      r = (i > 0) ? s[i-1] : 1'b0;
      n[i] = l ^ r;
    end
    return n;
  endfunction

  // Driver tasks: inputs change 1 time unit after the edge, sampling likewise.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rn, input logic ld, input logic [W-1:0] d);
    rst_n    = rn;
    bus.load = ld;
    bus.data = d;
  endtask

  task automatic step_model_check(input string tag);
    logic [W-1:0] e;
    m_state = model_step(m_state);
    exp_q.push_back(m_state);
    drive(1'b1, 1'b0, $urandom_range(0, 1) ? {W{1'b1}} : '0);
    tick();
    e = exp_q.pop_front();
    check_q(tag, bus.q, e);
  endtask

  logic [W-1:0] v_seed;
  logic [W-1:0] v_rand;

  initial begin
    n_checks = 0;
    n_pass   = 0;
    drive(1'b0, 1'b0, '0);
    #2;

    // 1: reset holds q at zero whatever load/data do
    for (int i = 0; i < 2; i++) begin
      v_rand = {16{$urandom()}};
      drive(1'b0, 1'b1, v_rand);
      tick();
      check_q("reset", bus.q, '0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, {W{1'b1}});
      tick();
      check_q("zero_fixed", bus.q, '0);
    end

    // 2: both end cells seeded, load held for 5 edges
    v_seed = bits4(0, W - 1, -1, -1);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, v_seed);
      tick();
      check_q("ends_load", bus.q, v_seed);
    end
    drive(1'b1, 1'b0, '0);
    tick();
    check_q("ends_step1", bus.q, bits4(1, W - 2, -1, -1));
    tick();
    check_q("ends_step2", bus.q, bits4(0, 2, W - 3, W - 1));

    // 6: continue 20 steps against the model, then a one-edge reset
    m_state = bits4(0, 2, W - 3, W - 1);
    for (int i = 0; i < 20; i++) step_model_check("evolve_model");
    drive(1'b0, 1'b0, '0);
    tick();
    check_q("midrun_reset", bus.q, '0);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, {W{1'b1}});
      tick();
      check_q("after_reset_zero", bus.q, '0);
    end

    // 3: single centre cell
    drive(1'b1, 1'b1, bits4(256, -1, -1, -1));
    tick();
    check_q("centre_load", bus.q, bits4(256, -1, -1, -1));
    drive(1'b1, 1'b0, '0);
    tick();
    check_q("centre_step1", bus.q, bits4(255, 257, -1, -1));
    tick();
    check_q("centre_step2", bus.q, bits4(254, 258, -1, -1));
    tick();
    check_q("centre_step3", bus.q, bits4(253, 255, 257, 259));

    // 4: all ones collapses to the two edge cells
    drive(1'b1, 1'b1, {W{1'b1}});
    tick();
    check_q("ones_load", bus.q, {W{1'b1}});
    drive(1'b1, 1'b0, '0);
    tick();
    check_q("ones_step1", bus.q, bits4(0, W - 1, -1, -1));

    // 5: reset overrides load on the same edge
    drive(1'b0, 1'b1, {W{1'b1}});
    tick();
    check_q("prio_reset", bus.q, '0);
    drive(1'b1, 1'b1, {W{1'b1}});
    tick();
    check_q("prio_load", bus.q, {W{1'b1}});

    // Random load followed by model-checked evolution
    v_rand = {16{$urandom()}};
    drive(1'b1, 1'b1, v_rand);
    tick();
    check_q("rand_load", bus.q, v_rand);
    m_state = v_rand;
    for (int i = 0; i < 8; i++) step_model_check("rand_model");

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
